fractal_sync_cnt_rf: RTL and testbench

Counting local synchronisation register file for fractal_sync nodes: the N-port, N-participant successor of the two-port, single-bit local RF. Each entry counts barrier arrivals for one synchronisation ID until a per-barrier threshold is met, then reports completion. Any number of ports may hit the same entry in the same cycle. It sits inside a fractal_sync node in place of the local RF; results feed the node's forward/backward arbitration.

---
 rtl/fractal_sync_pkg.sv | 24 ++
 rtl/fractal_sync_cnt_rf_entry.sv | 98 +++++++++
 rtl/fractal_sync_cnt_rf.sv | 92 +++++++++
 tb/tb_fractal_sync_cnt_rf.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// Shared types for fractal_sync nodes: response encoding of the counting local
// synchronisation register file and a threshold range helper.
package fractal_sync_pkg;

   typedef enum logic [2:0] {
      RSP_NONE    = 3'd0,
      RSP_IGNORE  = 3'd1,
      RSP_BYPASS  = 3'd2,
      RSP_ID_ERR  = 3'd3,
      RSP_SIG_ERR = 3'd4
   } cnt_rf_rsp_e;

   typedef struct packed {
      cnt_rf_rsp_e rsp;
      logic        present;
   } cnt_rf_rsp_t;

   localparam cnt_rf_rsp_t CNT_RF_RSP_IDLE = '{rsp: RSP_NONE, present: 1'b0};

   function automatic logic thr_in_range(input int unsigned thr, input int unsigned max_arrivals);
      return (thr >= 32'd2) && (thr <= max_arrivals);
   endfunction

endpackage

// File: rtl/fractal_sync_cnt_rf_entry.sv
// One counting barrier entry: classifies every port hitting it this cycle and
// updates its arrival count / threshold.
module fractal_sync_cnt_rf_entry
   import fractal_sync_pkg::*;
#(
   parameter int unsigned N_PORTS      = 2,
   parameter int unsigned MAX_ARRIVALS = 4,
   localparam int unsigned CNT_WIDTH   = $clog2(MAX_ARRIVALS + 1)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              flush_i,
   input  logic [N_PORTS-1:0]                hit_i,
   input  logic [N_PORTS-1:0][CNT_WIDTH-1:0] thr_i,
   output cnt_rf_rsp_t [N_PORTS-1:0]         rsp_o
);

   localparam int unsigned SUM_WIDTH = CNT_WIDTH + $clog2(N_PORTS + 1);

   logic [CNT_WIDTH-1:0] cnt_r, thr_r, cnt_d_s, thr_d_s;
   logic [CNT_WIDTH-1:0] cur_cnt_s, cur_thr_s, ref_thr_s;
   logic [N_PORTS-1:0]   legal_s, valid_s;
   logic [SUM_WIDTH-1:0] total_s, ref_ext_s;
   logic                 busy_s;

   // Flush makes this cycle's checks see an idle entry; the lowest legal port sets an idle reference.
   always_comb begin
      cur_cnt_s = flush_i ? '0 : cnt_r;
      cur_thr_s = flush_i ? '0 : thr_r;
      busy_s    = (cur_cnt_s != '0);
      ref_thr_s = cur_thr_s;
      legal_s   = '0;
      for (int p = int'(N_PORTS) - 1; p >= 0; p--) begin
         legal_s[p] = hit_i[p] && thr_in_range(32'(thr_i[p]), MAX_ARRIVALS);
         ref_thr_s  = (!busy_s && legal_s[p]) ? thr_i[p] : ref_thr_s;
      end
      valid_s = '0;
      total_s = SUM_WIDTH'(cur_cnt_s);
      for (int p = 0; p < int'(N_PORTS); p++) begin
         valid_s[p] = legal_s[p] && (thr_i[p] == ref_thr_s);
         total_s    = total_s + SUM_WIDTH'(valid_s[p]);
      end
      ref_ext_s = SUM_WIDTH'(ref_thr_s);
   end

   // Per-port classification; present tracks earlier arrivals, including lower same-cycle ports.
   always_comb begin
      logic seen;
      seen  = 1'b0;
      rsp_o = '0;
      for (int p = 0; p < int'(N_PORTS); p++) begin
         rsp_o[p] = CNT_RF_RSP_IDLE;
         if (!hit_i[p]) begin
            rsp_o[p].rsp = RSP_NONE;
         end else if (!valid_s[p]) begin
            rsp_o[p].rsp = RSP_SIG_ERR;
         end else if (total_s < ref_ext_s) begin
            rsp_o[p].rsp     = RSP_IGNORE;
            rsp_o[p].present = busy_s || seen;
         end else if (total_s == ref_ext_s) begin
            rsp_o[p].rsp     = RSP_BYPASS;
            rsp_o[p].present = busy_s || seen;
         end else begin
            rsp_o[p].rsp = RSP_SIG_ERR;
         end
         seen = seen || valid_s[p];
      end
   end

   // Next entry state: accumulate, complete, or hold on overflow.
   always_comb begin
      cnt_d_s = cur_cnt_s;
      thr_d_s = cur_thr_s;
      if (valid_s == '0) begin
         cnt_d_s = cur_cnt_s;
      end else if (total_s < ref_ext_s) begin
         cnt_d_s = CNT_WIDTH'(total_s);
         thr_d_s = ref_thr_s;
      end else if (total_s == ref_ext_s) begin
         cnt_d_s = '0;
         thr_d_s = '0;
      end else begin
         cnt_d_s = cur_cnt_s;
      end
   end

   // Entry state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_r <= '0;
         thr_r <= '0;
      end else begin
         cnt_r <= cnt_d_s;
         thr_r <= thr_d_s;
      end
   end

endmodule

// File: rtl/fractal_sync_cnt_rf.sv
// Counting local synchronisation register file: N ports, N_REGS barrier entries,
// one-cycle registered responses.
module fractal_sync_cnt_rf
   import fractal_sync_pkg::*;
#(
   parameter int unsigned N_PORTS      = 2,
   parameter int unsigned N_REGS       = 2,
   parameter int unsigned ID_WIDTH     = 1,
   parameter int unsigned MAX_ARRIVALS = 4,
   localparam int unsigned CNT_WIDTH   = $clog2(MAX_ARRIVALS + 1)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              flush_i,
   input  logic [N_PORTS-1:0]                check_i,
   input  logic [N_PORTS-1:0][ID_WIDTH-1:0]  id_i,
   input  logic [N_PORTS-1:0][CNT_WIDTH-1:0] thr_i,
   output logic [N_PORTS-1:0]                present_o,
   output logic [N_PORTS-1:0]                bypass_o,
   output logic [N_PORTS-1:0]                ignore_o,
   output logic [N_PORTS-1:0]                id_err_o,
   output logic [N_PORTS-1:0]                sig_err_o
);

   logic [N_REGS-1:0][N_PORTS-1:0] hit_s;
   logic [N_PORTS-1:0]             id_ok_s;
   cnt_rf_rsp_t [N_PORTS-1:0]      entry_rsp_s [N_REGS];
   cnt_rf_rsp_t [N_PORTS-1:0]      rsp_d_s, rsp_r;

   // Id decode into per-entry hit vectors.
   always_comb begin
      hit_s = '0;
      for (int p = 0; p < int'(N_PORTS); p++) begin
         id_ok_s[p] = (32'(id_i[p]) < N_REGS);
         for (int r = 0; r < int'(N_REGS); r++) begin
            hit_s[r][p] = check_i[p] && id_ok_s[p] && (32'(id_i[p]) == 32'(r));
         end
      end
   end

   for (genvar r = 0; r < int'(N_REGS); r++) begin : g_entry
      fractal_sync_cnt_rf_entry #(
         .N_PORTS      (N_PORTS),
         .MAX_ARRIVALS (MAX_ARRIVALS)
      ) u_entry (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .flush_i (flush_i),
         .hit_i   (hit_s[r]),
         .thr_i   (thr_i),
         .rsp_o   (entry_rsp_s[r])
      );
   end

   // Select each port's response from the entry it addressed.
   always_comb begin
      rsp_d_s = '0;
      for (int p = 0; p < int'(N_PORTS); p++) begin
         rsp_d_s[p] = CNT_RF_RSP_IDLE;
         if (!check_i[p]) begin
            rsp_d_s[p] = CNT_RF_RSP_IDLE;
         end else if (!id_ok_s[p]) begin
            rsp_d_s[p] = '{rsp: RSP_ID_ERR, present: 1'b0};
         end else begin
            for (int r = 0; r < int'(N_REGS); r++) begin
               rsp_d_s[p] = hit_s[r][p] ? entry_rsp_s[r][p] : rsp_d_s[p];
            end
         end
      end
   end

   // Response registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_r <= '0;
      end else begin
         rsp_r <= rsp_d_s;
      end
   end

   // One-hot output decode.
   always_comb begin
      for (int p = 0; p < int'(N_PORTS); p++) begin
         present_o[p] = rsp_r[p].present;
         ignore_o[p]  = (rsp_r[p].rsp == RSP_IGNORE);
         bypass_o[p]  = (rsp_r[p].rsp == RSP_BYPASS);
         id_err_o[p]  = (rsp_r[p].rsp == RSP_ID_ERR);
         sig_err_o[p] = (rsp_r[p].rsp == RSP_SIG_ERR);
      end
   end

endmodule

// File: tb/tb_fractal_sync_cnt_rf.sv
// Scoreboard bench for fractal_sync_cnt_rf: directed checks push expected
// responses; a negedge monitor pops and compares them one cycle later.
module tb_fractal_sync_cnt_rf;

   localparam logic [2:0] C_N = 3'd0, C_I = 3'd1, C_B = 3'd2, C_D = 3'd3, C_S = 3'd4;

   logic             clk = 1'b0;
   logic             rst_ni = 1'b0;
   logic             flush;
   logic [3:0]       check;
   logic [3:0][1:0]  id;
   logic [3:0][2:0]  thr;
   logic [3:0]       present, bypass, ignore, id_err, sig_err;

   typedef struct {
      int              due;
      logic [3:0][2:0] code;
      logic [3:0]      pres;
      int              tag;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   fractal_sync_cnt_rf #(
      .N_PORTS      (4),
      .N_REGS       (2),
      .ID_WIDTH     (2),
      .MAX_ARRIVALS (4)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .flush_i   (flush),
      .check_i   (check),
      .id_i      (id),
      .thr_i     (thr),
      .present_o (present),
      .bypass_o  (bypass),
      .ignore_o  (ignore),
      .id_err_o  (id_err),
      .sig_err_o (sig_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [2:0] code_of(input logic i, input logic b, input logic d, input logic s);
      case ({i, b, d, s})
         4'b0000: return C_N;
         4'b1000: return C_I;
         4'b0100: return C_B;
         4'b0010: return C_D;
         4'b0001: return C_S;
         default: return 3'd7;
      endcase
   endfunction

   // Monitor: compare the response due this cycle
   always @(negedge clk) begin
      exp_t            e;
      logic [3:0][2:0] act;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         for (int p = 0; p < 4; p++) act[p] = code_of(ignore[p], bypass[p], id_err[p], sig_err[p]);
         total++;
         if (act !== e.code || present !== e.pres) begin
            bad++;
            $display("FAIL step%0d: got code=%h present=%b, expected code=%h present=%b",
                     e.tag, act, present, e.code, e.pres);
         end
      end
   end

   task automatic drive(input logic [3:0] c, input logic [3:0][1:0] i, input logic [3:0][2:0] t,
                        input logic f, input logic [3:0][2:0] ec, input logic [3:0] ep, input int tag);
      exp_t e;
      @(negedge clk);
      check = c;
      id    = i;
      thr   = t;
      flush = f;
      e.due  = cyc + 1;
      e.code = ec;
      e.pres = ep;
      e.tag  = tag;
      q.push_back(e);
   endtask

   task automatic one(input int p, input logic [1:0] i, input logic [2:0] t, input logic f,
                      input logic [2:0] ec, input logic ep, input int tag);
      logic [3:0]      c;
      logic [3:0][1:0] iv;
      logic [3:0][2:0] tv;
      logic [3:0][2:0] ecv;
      logic [3:0]      epv;
      c = '0; iv = '0; tv = '0; ecv = '0; epv = '0;
      c[p] = 1'b1; iv[p] = i; tv[p] = t; ecv[p] = ec; epv[p] = ep;
      drive(c, iv, tv, f, ecv, epv, tag);
   endtask

   task automatic idle(input int tag);
      drive(4'b0000, '0, '0, 1'b0, '0, 4'b0000, tag);
   endtask

   task automatic chk_zero(input string name);
      total++;
      if ({present, bypass, ignore, id_err, sig_err} !== 20'd0) begin
         bad++;
         $display("FAIL %s: outputs p=%b b=%b i=%b d=%b s=%b, expected all 0",
                  name, present, bypass, ignore, id_err, sig_err);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      check = '0; id = '0; thr = '0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      @(negedge clk) rst_ni = 1'b1;
      idle(1);
      // two-arrival barrier, then idle again after completion
      one(0, 2'd0, 3'd2, 1'b0, C_I, 1'b0, 2);
      idle(3);
      idle(4);
      one(1, 2'd0, 3'd2, 1'b0, C_B, 1'b1, 5);
      one(0, 2'd0, 3'd2, 1'b0, C_I, 1'b0, 6);
      one(0, 2'd0, 3'd2, 1'b0, C_B, 1'b1, 7);
      // four simultaneous arrivals complete a thr=4 barrier
      drive(4'b1111, {2'd1, 2'd1, 2'd1, 2'd1}, {3'd4, 3'd4, 3'd4, 3'd4}, 1'b0,
            {C_B, C_B, C_B, C_B}, 4'b1110, 8);
      // overflow leaves count at 2
      one(0, 2'd0, 3'd3, 1'b0, C_I, 1'b0, 9);
      one(0, 2'd0, 3'd3, 1'b0, C_I, 1'b1, 10);
      drive(4'b0111, '0, {3'd0, 3'd3, 3'd3, 3'd3}, 1'b0, {C_N, C_S, C_S, C_S}, 4'b0000, 11);
      one(3, 2'd0, 3'd3, 1'b0, C_B, 1'b1, 12);
      // id and threshold errors
      drive(4'b0101, {2'd0, 2'd3, 2'd0, 2'd2}, {3'd0, 3'd2, 3'd0, 3'd2}, 1'b0,
            {C_N, C_D, C_N, C_D}, 4'b0000, 13);
      one(0, 2'd0, 3'd3, 1'b0, C_I, 1'b0, 14);
      one(1, 2'd0, 3'd2, 1'b0, C_S, 1'b0, 15);
      one(0, 2'd0, 3'd1, 1'b0, C_S, 1'b0, 16);
      one(0, 2'd0, 3'd5, 1'b0, C_S, 1'b0, 17);
      one(0, 2'd0, 3'd3, 1'b0, C_I, 1'b1, 18);
      one(1, 2'd0, 3'd3, 1'b0, C_B, 1'b1, 19);
      // idle reference from lowest legal port; entries independent
      drive(4'b0111, {2'd0, 2'd0, 2'd1, 2'd1}, {3'd0, 3'd2, 3'd2, 3'd3}, 1'b0,
            {C_N, C_I, C_S, C_I}, 4'b0000, 20);
      drive(4'b0011, {2'd0, 2'd0, 2'd1, 2'd1}, {3'd0, 3'd0, 3'd3, 3'd3}, 1'b0,
            {C_N, C_N, C_B, C_B}, 4'b0011, 21);
      one(0, 2'd0, 3'd2, 1'b0, C_B, 1'b1, 22);
      drive(4'b0011, '0, {3'd0, 3'd0, 3'd2, 3'd1}, 1'b0, {C_N, C_N, C_I, C_S}, 4'b0000, 23);
      one(0, 2'd0, 3'd2, 1'b0, C_B, 1'b1, 24);
      // completion plus an extra same-cycle arrival overflows
      one(0, 2'd0, 3'd2, 1'b0, C_I, 1'b0, 25);
      drive(4'b0011, '0, {3'd0, 3'd0, 3'd2, 3'd2}, 1'b0, {C_N, C_N, C_S, C_S}, 4'b0000, 26);
      one(1, 2'd0, 3'd2, 1'b0, C_B, 1'b1, 27);
      // asynchronous reset mid-barrier
      one(0, 2'd0, 3'd2, 1'b0, C_I, 1'b0, 28);
      @(negedge clk);
      check = '0;
      #1 rst_ni = 1'b0;
      #1 chk_zero("async_reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_ni = 1'b1;
      one(0, 2'd0, 3'd2, 1'b0, C_I, 1'b0, 30);
      one(0, 2'd0, 3'd2, 1'b0, C_B, 1'b1, 31);
      // flush with a check on a busy entry
      one(0, 2'd0, 3'd3, 1'b0, C_I, 1'b0, 32);
      one(0, 2'd0, 3'd3, 1'b0, C_I, 1'b1, 33);
      one(0, 2'd0, 3'd3, 1'b1, C_I, 1'b0, 34);
      one(0, 2'd0, 3'd3, 1'b0, C_I, 1'b1, 35);
      one(0, 2'd0, 3'd3, 1'b0, C_B, 1'b1, 36);
      // plain flush clears a pending barrier and its threshold
      one(0, 2'd1, 3'd4, 1'b0, C_I, 1'b0, 37);
      drive(4'b0000, '0, '0, 1'b1, '0, 4'b0000, 38);
      one(0, 2'd1, 3'd2, 1'b0, C_I, 1'b0, 39);
      one(0, 2'd1, 3'd2, 1'b0, C_B, 1'b1, 40);
      idle(41);
      idle(42);
      @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expected responses never checked, expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
